// File: rtl/cache_ctrl.sv
// Miss-handling controller between the CPU port, an external cache array and a word-wide memory.
// Define CACHE_CTRL_STATS_EN to add saturating hit/miss counters (stats_clr, hit_cnt, miss_cnt).
module cache_ctrl #(
   parameter int unsigned MEM_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cpu_req,
   input  logic        cpu_wr,
   input  logic [14:0] cpu_addr,
   input  logic [15:0] cpu_wdata,
   output logic        cpu_ready,
   output logic [15:0] cpu_rdata,
   output logic        cpu_busy,
   output logic        err,
   output logic        c_enable,
   output logic        c_comp,
   output logic        c_write,
   output logic        c_valid_in,
   output logic [7:0]  c_index,
   output logic [1:0]  c_word,
   output logic [4:0]  c_tag_in,
   output logic [15:0] c_data_in,
   input  logic        c_hit,
   input  logic        c_dirty,
   input  logic        c_valid,
   input  logic [4:0]  c_tag_out,
   input  logic [15:0] c_data_out,
   output logic        mem_req,
   output logic        mem_wr,
   output logic [14:0] mem_addr,
   output logic [15:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [15:0] mem_rdata
`ifdef CACHE_CTRL_STATS_EN
   ,
   input  logic        stats_clr,
   output logic [15:0] hit_cnt,
   output logic [15:0] miss_cnt
`endif
);

   localparam int unsigned TAG_W   = 5;
   localparam int unsigned IDX_W   = 8;
   localparam int unsigned WRD_W   = 2;
   localparam int unsigned DATA_W  = 16;
   localparam int unsigned ADDR_W  = TAG_W + IDX_W + WRD_W;
   localparam int unsigned TO_W    = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
   localparam int unsigned TO_LAST = (MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1;
   localparam bit          TO_EN   = (MEM_TIMEOUT != 0);

   typedef enum logic [2:0] {
      S_IDLE,
      S_COMPARE,
      S_WB,
      S_FILL,
      S_DONE
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                wr_q, wr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic [TAG_W-1:0]    victim_q, victim_d;
   logic [WRD_W-1:0]    word_q, word_d;
   logic                gap_q, gap_d;
   logic                replay_q, replay_d;
   logic [TO_W-1:0]     to_cnt_q, to_cnt_d;

   logic [TAG_W-1:0]    req_tag;
   logic [IDX_W-1:0]    req_idx;
   logic [WRD_W-1:0]    req_word;
   logic                ack_c;
   logic                wait_c;
   logic                timeout_c;

   assign req_tag   = addr_q[ADDR_W-1 -: TAG_W];
   assign req_idx   = addr_q[WRD_W +: IDX_W];
   assign req_word  = addr_q[WRD_W-1:0];

   // Request drops for one cycle after every accepted word; async reset kills it immediately.
   assign mem_req   = ((state_q == S_WB) || (state_q == S_FILL)) && !gap_q;
   assign ack_c     = mem_req && mem_ack;
   assign wait_c    = mem_req && !mem_ack;
   assign timeout_c = TO_EN && wait_c && (to_cnt_q == TO_W'(TO_LAST));

   assign cpu_busy  = (state_q != S_IDLE);
   assign cpu_rdata = (state_q == S_DONE) ? rdata_q : '0;

   // Next-state and cache/memory drive.
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      wr_d       = wr_q;
      wdata_d    = wdata_q;
      rdata_d    = rdata_q;
      victim_d   = victim_q;
      word_d     = word_q;
      gap_d      = 1'b0;
      replay_d   = replay_q;
      to_cnt_d   = wait_c ? to_cnt_q + TO_W'(1) : '0;
      c_enable   = 1'b0;
      c_comp     = 1'b0;
      c_write    = 1'b0;
      c_valid_in = 1'b0;
      c_index    = '0;
      c_word     = '0;
      c_tag_in   = '0;
      c_data_in  = '0;
      mem_wr     = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      cpu_ready  = 1'b0;
      err        = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (cpu_req) begin
               addr_d   = cpu_addr;
               wr_d     = cpu_wr;
               wdata_d  = cpu_wdata;
               replay_d = 1'b0;
               word_d   = '0;
               state_d  = S_COMPARE;
            end
         end
         S_COMPARE: begin
            c_enable  = 1'b1;
            c_comp    = 1'b1;
            c_write   = wr_q;
            c_index   = req_idx;
            c_word    = req_word;
            c_tag_in  = req_tag;
            c_data_in = wdata_q;
            word_d    = '0;
            if (c_hit && c_valid) begin
               rdata_d = wr_q ? '0 : c_data_out;
               state_d = S_DONE;
            end else if (c_valid && c_dirty) begin
               victim_d = c_tag_out;
               state_d  = S_WB;
            end else begin
               state_d  = S_FILL;
            end
         end
         S_WB: begin
            c_enable  = 1'b1;
            c_index   = req_idx;
            c_word    = word_q;
            mem_wr    = mem_req;
            mem_addr  = {victim_q, req_idx, word_q};
            mem_wdata = c_data_out;
            if (ack_c) begin
               gap_d  = 1'b1;
               word_d = word_q + WRD_W'(1);
               if (word_q == WRD_W'(3)) state_d = S_FILL;
            end else if (timeout_c) begin
               cpu_ready = 1'b1;
               err       = 1'b1;
               word_d    = '0;
               to_cnt_d  = '0;
               state_d   = S_IDLE;
            end
         end
         S_FILL: begin
            c_index   = req_idx;
            c_word    = word_q;
            c_tag_in  = req_tag;
            c_data_in = mem_rdata;
            mem_addr  = {req_tag, req_idx, word_q};
            if (ack_c) begin
               c_enable   = 1'b1;
               c_write    = 1'b1;
               c_valid_in = (word_q == WRD_W'(3));
               gap_d      = 1'b1;
               word_d     = word_q + WRD_W'(1);
               if (word_q == WRD_W'(3)) begin
                  replay_d = 1'b1;
                  state_d  = S_COMPARE;
               end
            end else if (timeout_c) begin
               // Abandoned fill: make sure the line is left invalid.
               c_enable  = 1'b1;
               c_write   = 1'b1;
               cpu_ready = 1'b1;
               err       = 1'b1;
               word_d    = '0;
               to_cnt_d  = '0;
               state_d   = S_IDLE;
            end
         end
         S_DONE: begin
            cpu_ready = 1'b1;
            state_d   = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         addr_q   <= '0;
         wr_q     <= 1'b0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         victim_q <= '0;
         word_q   <= '0;
         gap_q    <= 1'b0;
         replay_q <= 1'b0;
         to_cnt_q <= '0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         wr_q     <= wr_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
         victim_q <= victim_d;
         word_q   <= word_d;
         gap_q    <= gap_d;
         replay_q <= replay_d;
         to_cnt_q <= to_cnt_d;
      end
   end

`ifdef CACHE_CTRL_STATS_EN
   logic        hit_inc, miss_inc;
   logic [15:0] hit_cnt_q, miss_cnt_q;

   // Only the first compare of an access is counted; the post-fill replay is not.
   always_comb begin
      hit_inc  = (state_q == S_COMPARE) && !replay_q && c_hit && c_valid;
      miss_inc = (state_q == S_COMPARE) && !replay_q && !(c_hit && c_valid);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else if (stats_clr) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         if (hit_inc && (hit_cnt_q != 16'hFFFF))   hit_cnt_q  <= hit_cnt_q + 16'd1;
         if (miss_inc && (miss_cnt_q != 16'hFFFF)) miss_cnt_q <= miss_cnt_q + 16'd1;
      end
   end

   assign hit_cnt  = hit_cnt_q;
   assign miss_cnt = miss_cnt_q;
`endif

endmodule
